// File: rtl/nios_dbg_pkg.sv
// nios_dbg_pkg: shared width defaults, command channel enum and FIFO entry type
package nios_dbg_pkg;
    localparam int IR_W_DEF = 2;
    localparam int DR_W_DEF = 38;
    typedef enum logic [IR_W_DEF-1:0] {
        OCIMEM    = 2'd0,
        TRACEMEM  = 2'd1,
        BREAK     = 2'd2,
        TRACECTRL = 2'd3
    } cmd_ch_e;
    typedef struct packed {
        logic [IR_W_DEF-1:0] ir;
        logic [DR_W_DEF-1:0] data;
    } fifo_entry_t;
endpackage

// File: rtl/nios_dbg_strobe_sync.sv
// nios_dbg_strobe_sync: SYNC_STAGES-flop synchroniser with registered rising-edge detect
module nios_dbg_strobe_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic rise
);
    logic [SYNC_STAGES-1:0] sync_q, sync_d, fill_q, fill_d;
    logic hist_q, hist_d, rise_q, rise_d;
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
        fill_d = {fill_q[SYNC_STAGES-2:0], 1'b1};
        // history stays high until the chain holds real samples, so a level already high at reset release never looks like an edge
        hist_d = fill_q[SYNC_STAGES-1] ? sync_q[SYNC_STAGES-1] : 1'b1;
        rise_d = sync_q[SYNC_STAGES-1] & ~hist_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            fill_q <= '0;
            hist_q <= 1'b1;
            rise_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            fill_q <= fill_d;
            hist_q <= hist_d;
            rise_q <= rise_d;
        end
    end
    assign rise = rise_q;
endmodule

// File: rtl/nios_dbg_cmd_sysclk.sv
// nios_dbg_cmd_sysclk: JTAG debug command capture, queue and issue; NIOS_DBG_CMD_TIMEOUT_EN adds stall discard
module nios_dbg_cmd_sysclk
    import nios_dbg_pkg::*;
#(
    parameter int IR_W           = IR_W_DEF,
    parameter int DR_W           = DR_W_DEF,
    parameter int SYNC_STAGES    = 2,
    parameter int ACTION_BIT     = 35,
    parameter int FIFO_DEPTH     = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 vs_uir,
    input  logic                 vs_udr,
    input  logic [IR_W-1:0]      ir_in,
    input  logic [DR_W-1:0]      sr,
    output logic                 cmd_valid,
    input  logic                 cmd_ready,
    output logic [IR_W-1:0]      cmd_ir,
    output logic [DR_W-1:0]      cmd_data,
    output logic [DR_W-1:0]      jdo,
    output logic [(1<<IR_W)-1:0] take_action,
    output logic [(1<<IR_W)-1:0] take_no_action,
    output logic                 overrun,
    input  logic                 overrun_clr,
    output logic                 timeout
);
    localparam int NCH = 1 << IR_W;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int PW  = AW + 1;
    localparam int EW  = IR_W + DR_W;
    logic uir_rise, udr_rise;
    logic [IR_W-1:0] ir_q, ir_d;
    logic [EW-1:0] mem_q [FIFO_DEPTH];
    logic [EW-1:0] head;
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [DR_W-1:0] jdo_q, jdo_d;
    logic [NCH-1:0] act_q, act_d, nact_q, nact_d, onehot;
    logic overrun_q, overrun_d, full, accept, drop, pop, push;

    nios_dbg_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_uir (
        .clk(clk), .reset(reset), .async_in(vs_uir), .rise(uir_rise));
    nios_dbg_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_udr (
        .clk(clk), .reset(reset), .async_in(vs_udr), .rise(udr_rise));

    assign head      = mem_q[rd_q[AW-1:0]];
    assign cmd_valid = wr_q != rd_q;
    assign full      = (wr_q ^ rd_q) == {1'b1, {AW{1'b0}}};
    assign accept    = cmd_valid & cmd_ready;
    assign pop       = accept | drop;
    assign push      = udr_rise & (~full | pop);
    assign onehot    = {{(NCH-1){1'b0}}, 1'b1} << head[EW-1:DR_W];

    always_comb begin
        ir_d      = uir_rise ? ir_in : ir_q;
        wr_d      = wr_q + PW'(push);
        rd_d      = rd_q + PW'(pop);
        jdo_d     = accept ? head[DR_W-1:0] : jdo_q;
        act_d     = (accept & head[ACTION_BIT]) ? onehot : '0;
        nact_d    = (accept & ~head[ACTION_BIT]) ? onehot : '0;
        overrun_d = (udr_rise & ~push) | (overrun_q & ~overrun_clr);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ir_q      <= '0;
            wr_q      <= '0;
            rd_q      <= '0;
            jdo_q     <= '0;
            act_q     <= '0;
            nact_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            ir_q      <= ir_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            jdo_q     <= jdo_d;
            act_q     <= act_d;
            nact_q    <= nact_d;
            overrun_q <= overrun_d;
        end
    end

    // a simultaneous IR update wins, so ir_d rather than ir_q is stored
    always_ff @(posedge clk)
        if (push) mem_q[wr_q[AW-1:0]] <= {ir_d, sr};

`ifdef NIOS_DBG_CMD_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CW-1:0] cnt_q, cnt_d;
    logic timeout_q, timeout_d;
    assign drop = cmd_valid & ~cmd_ready & (cnt_q == CW'(TIMEOUT_CYCLES - 1));
    always_comb begin
        cnt_d     = pop ? '0 : (cmd_valid & ~cmd_ready) ? cnt_q + CW'(1) : cnt_q;
        timeout_d = drop | (timeout_q & ~overrun_clr);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end
    assign timeout = timeout_q;
`else
    assign drop    = 1'b0;
    assign timeout = 1'b0;
`endif

    assign cmd_ir         = head[EW-1:DR_W];
    assign cmd_data       = head[DR_W-1:0];
    assign jdo            = jdo_q;
    assign take_action    = act_q;
    assign take_no_action = nact_q;
    assign overrun        = overrun_q;
endmodule

// File: tb/tb_nios_dbg_cmd_sysclk.sv
// tb_nios_dbg_cmd_sysclk: randomized scenario bench with a queue-based command reference model
module tb_nios_dbg_cmd_sysclk;
    localparam int IR_W = 2;
    localparam int DR_W = 38;
    localparam int NCH  = 4;
    localparam int TO   = 8;
    logic clk = 0, reset = 1, vs_uir = 0, vs_udr = 0, cmd_ready = 0, overrun_clr = 0;
    logic [IR_W-1:0] ir_in = 0;
    logic [DR_W-1:0] sr = 0;
    logic cmd_valid, overrun, timeout;
    logic [IR_W-1:0] cmd_ir;
    logic [DR_W-1:0] cmd_data, jdo;
    logic [NCH-1:0] take_action, take_no_action;

    typedef struct { logic [NCH-1:0] act; logic [NCH-1:0] nact; logic [DR_W-1:0] jdo; int cyc; } obs_t;
    typedef struct { logic [IR_W-1:0] ir; logic [DR_W-1:0] data; } cmd_t;
    obs_t obs[$];
    int checks = 0, failures = 0, cyc = 0;

    nios_dbg_cmd_sysclk #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .vs_uir(vs_uir), .vs_udr(vs_udr), .ir_in(ir_in), .sr(sr),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir), .cmd_data(cmd_data),
        .jdo(jdo), .take_action(take_action), .take_no_action(take_no_action),
        .overrun(overrun), .overrun_clr(overrun_clr), .timeout(timeout));

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk); #1; cyc++;
            if (take_action != 0 || take_no_action != 0) obs.push_back('{take_action, take_no_action, jdo, cyc});
        end
    endtask

    function automatic logic [NCH-1:0] exp_vec(input cmd_t c, input bit want_act);
        return (c.data[35] == want_act) ? (4'b0001 << c.ir) : 4'b0000;
    endfunction

    function automatic cmd_t rand_cmd();
        cmd_t c;
        c.ir = IR_W'($urandom_range(0, NCH - 1));
        c.data = DR_W'({$urandom, $urandom});
        return c;
    endfunction

    task automatic strobe(input bit u, input bit d);
        vs_uir = u; vs_udr = d;
        tick(3);
        vs_uir = 0; vs_udr = 0;
        tick(4);
    endtask

    task automatic send(input cmd_t c, input bit combined);
        ir_in = c.ir;
        if (!combined) strobe(1, 0);
        sr = c.data;
        strobe(combined, 1);
    endtask

    task automatic test_reset();
        logic [DR_W-1:0] d;
        reset = 1; vs_udr = 1;
        tick(3);
        reset = 0;
        tick(1);
        checks++; if (cmd_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", cmd_valid); end
        checks++; if (take_action !== 4'b0 || take_no_action !== 4'b0) begin failures++; $display("FAIL reset_take got=%b/%b exp=0000/0000", take_action, take_no_action); end
        checks++; if (jdo !== '0) begin failures++; $display("FAIL reset_jdo got=%0h exp=0", jdo); end
        checks++; if (overrun !== 1'b0 || timeout !== 1'b0) begin failures++; $display("FAIL reset_flags got=%0b%0b exp=00", overrun, timeout); end
        tick(10);
        checks++; if (cmd_valid !== 1'b0) begin failures++; $display("FAIL held_udr_ignored got=%0b exp=0", cmd_valid); end
        d = DR_W'({$urandom, $urandom});
        sr = d; vs_udr = 0;
        tick(4);
        vs_udr = 1;
        tick(4);
        checks++; if (cmd_valid !== 1'b1 || cmd_data !== d || cmd_ir !== 2'd0) begin failures++; $display("FAIL rearmed_push got=%0b/%0h/%0d exp=1/%0h/0", cmd_valid, cmd_data, cmd_ir, d); end
        vs_udr = 0;
        tick(4);
        reset = 1; tick(1); reset = 0; tick(1);
    endtask

    task automatic test_basic();
        int n;
        cmd_ready = 1;
        ir_in = 2;
        strobe(1, 0);
        sr = DR_W'({$urandom, $urandom});
        sr[35] = 1'b1;
        sr[31:0] = 32'hDEADBEEF;
        vs_udr = 1; n = 0;
        do begin tick(1); n++; end while (!cmd_valid && n < 20);
        checks++; if (n != 4) begin failures++; $display("FAIL valid_latency got=%0d exp=4", n); end
        tick(1);
        checks++; if (take_action !== 4'b0100 || take_no_action !== 4'b0) begin failures++; $display("FAIL basic_take got=%b/%b exp=0100/0000", take_action, take_no_action); end
        checks++; if (jdo[31:0] !== 32'hDEADBEEF) begin failures++; $display("FAIL basic_jdo got=%0h exp=deadbeef", jdo[31:0]); end
        tick(1);
        checks++; if (take_action !== 4'b0) begin failures++; $display("FAIL basic_single_pulse got=%b exp=0000", take_action); end
        vs_udr = 0;
        tick(4);
    endtask

    task automatic test_random();
        cmd_t exp[$];
        cmd_t c;
        cmd_ready = 1;
        obs.delete();
        for (int i = 0; i < 24; i++) begin
            c = rand_cmd();
            send(c, 1'($urandom_range(0, 1)));
            exp.push_back(c);
        end
        tick(4);
        checks++; if (obs.size() != exp.size()) begin failures++; $display("FAIL random_count got=%0d exp=%0d", obs.size(), exp.size()); end
        for (int i = 0; i < obs.size() && i < exp.size(); i++) begin
            checks++;
            if (obs[i].act !== exp_vec(exp[i], 1) || obs[i].nact !== exp_vec(exp[i], 0) || obs[i].jdo !== exp[i].data) begin
                failures++;
                $display("FAIL random_cmd%0d got=%b/%b/%0h exp=%b/%b/%0h", i, obs[i].act, obs[i].nact, obs[i].jdo,
                         exp_vec(exp[i], 1), exp_vec(exp[i], 0), exp[i].data);
            end
        end
    endtask

    task automatic test_overrun();
        cmd_t c[3];
        cmd_ready = 0;
        obs.delete();
        for (int i = 0; i < 3; i++) begin
            c[i] = rand_cmd();
            send(c[i], 0);
        end
        checks++; if (cmd_valid !== 1'b1 || overrun !== 1'b1) begin failures++; $display("FAIL overrun_set got=%0b/%0b exp=1/1", cmd_valid, overrun); end
        checks++; if (cmd_data !== c[0].data || obs.size() != 0) begin failures++; $display("FAIL overrun_head got=%0h/%0d exp=%0h/0", cmd_data, obs.size(), c[0].data); end
        cmd_ready = 1;
        tick(3);
        cmd_ready = 0;
        checks++; if (obs.size() != 2) begin failures++; $display("FAIL overrun_drain got=%0d exp=2", obs.size()); end
        if (obs.size() == 2) begin
            checks++; if (obs[0].jdo !== c[0].data || obs[1].jdo !== c[1].data) begin failures++; $display("FAIL overrun_order got=%0h,%0h exp=%0h,%0h", obs[0].jdo, obs[1].jdo, c[0].data, c[1].data); end
            checks++; if (obs[1].cyc != obs[0].cyc + 1) begin failures++; $display("FAIL overrun_b2b got=%0d exp=%0d", obs[1].cyc, obs[0].cyc + 1); end
            checks++; if (obs[1].act !== exp_vec(c[1], 1) || obs[1].nact !== exp_vec(c[1], 0)) begin failures++; $display("FAIL overrun_vec got=%b/%b exp=%b/%b", obs[1].act, obs[1].nact, exp_vec(c[1], 1), exp_vec(c[1], 0)); end
        end
        checks++; if (cmd_valid !== 1'b0 || overrun !== 1'b1) begin failures++; $display("FAIL overrun_sticky got=%0b/%0b exp=0/1", cmd_valid, overrun); end
        overrun_clr = 1;
        tick(1);
        overrun_clr = 0;
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL overrun_clr got=%0b exp=0", overrun); end
    endtask

    task automatic test_full_pushpop();
        cmd_t c[3];
        cmd_ready = 0;
        obs.delete();
        for (int i = 0; i < 3; i++) c[i] = rand_cmd();
        send(c[0], 0);
        send(c[1], 0);
        ir_in = c[2].ir;
        strobe(1, 0);
        sr = c[2].data;
        vs_udr = 1;
        tick(3);
        cmd_ready = 1;
        tick(1);
        cmd_ready = 0;
        vs_udr = 0;
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL pushpop_overrun got=%0b exp=0", overrun); end
        checks++; if (obs.size() != 1 || cmd_valid !== 1'b1 || cmd_data !== c[1].data) begin failures++; $display("FAIL pushpop_head got=%0d/%0b/%0h exp=1/1/%0h", obs.size(), cmd_valid, cmd_data, c[1].data); end
        tick(4);
        cmd_ready = 1;
        tick(4);
        cmd_ready = 0;
        checks++; if (obs.size() != 3) begin failures++; $display("FAIL pushpop_count got=%0d exp=3", obs.size()); end
        if (obs.size() == 3) begin
            checks++; if (obs[0].jdo !== c[0].data || obs[1].jdo !== c[1].data || obs[2].jdo !== c[2].data) begin failures++; $display("FAIL pushpop_order got=%0h,%0h,%0h exp=%0h,%0h,%0h", obs[0].jdo, obs[1].jdo, obs[2].jdo, c[0].data, c[1].data, c[2].data); end
        end
        checks++; if (cmd_valid !== 1'b0) begin failures++; $display("FAIL pushpop_empty got=%0b exp=0", cmd_valid); end
    endtask

    task automatic test_timeout();
        cmd_t c;
        int n, m;
        logic [DR_W-1:0] jdo_before;
        cmd_ready = 0;
        obs.delete();
        jdo_before = jdo;
        c = rand_cmd();
        ir_in = c.ir;
        strobe(1, 0);
        sr = c.data;
        vs_udr = 1; n = 0; m = 0;
        do begin tick(1); n++; end while (!cmd_valid && n < 20);
        vs_udr = 0;
`ifdef NIOS_DBG_CMD_TIMEOUT_EN
        while (cmd_valid && m < 50) begin tick(1); m++; end
        checks++; if (m != TO) begin failures++; $display("FAIL timeout_cycles got=%0d exp=%0d", m, TO); end
        checks++; if (timeout !== 1'b1 || obs.size() != 0 || jdo !== jdo_before) begin failures++; $display("FAIL timeout_drop got=%0b/%0d/%0h exp=1/0/%0h", timeout, obs.size(), jdo, jdo_before); end
        overrun_clr = 1;
        tick(1);
        overrun_clr = 0;
        checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL timeout_clr got=%0b exp=0", timeout); end
`else
        while (cmd_valid && m < 100) begin tick(1); m++; end
        checks++; if (m != 100 || timeout !== 1'b0 || obs.size() != 0) begin failures++; $display("FAIL no_timeout got=%0d/%0b/%0d exp=100/0/0", m, timeout, obs.size()); end
        cmd_ready = 1;
        tick(2);
        cmd_ready = 0;
        checks++; if (obs.size() != 1 || jdo !== c.data) begin failures++; $display("FAIL no_timeout_pop got=%0d/%0h exp=1/%0h", obs.size(), jdo, c.data); end
`endif
        tick(4);
    endtask

    task automatic test_reset_mid();
        cmd_t c;
        cmd_ready = 0;
        c = rand_cmd();
        c.data[0] = 1'b1;
        send(c, 0);
        send(rand_cmd(), 1);
        checks++; if (cmd_valid !== 1'b1 || cmd_data !== c.data) begin failures++; $display("FAIL mid_queued got=%0b/%0h exp=1/%0h", cmd_valid, cmd_data, c.data); end
        obs.delete();
        reset = 1; cmd_ready = 1;
        tick(1);
        checks++; if (cmd_valid !== 1'b0 || jdo !== '0) begin failures++; $display("FAIL mid_reset got=%0b/%0h exp=0/0", cmd_valid, jdo); end
        checks++; if (take_action !== 4'b0 || take_no_action !== 4'b0) begin failures++; $display("FAIL mid_reset_take got=%b/%b exp=0000/0000", take_action, take_no_action); end
        reset = 0;
        tick(4);
        checks++; if (obs.size() != 0 || cmd_valid !== 1'b0) begin failures++; $display("FAIL mid_after got=%0d/%0b exp=0/0", obs.size(), cmd_valid); end
        cmd_ready = 0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_random();
        test_overrun();
        test_full_pushpop();
        test_timeout();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/nios_dbg_cmd_sysclk.md
Name: nios_dbg_cmd_sysclk

Overview:
- System-clock half of the Nios debug-module JTAG path, generalised.
- Takes update-IR and update-DR strobes from the TCK domain as asynchronous levels, synchronises them, and captures the IR and scanned data register.
- Queues each scanned command in a small FIFO and issues it to the CPU debug logic over a valid/ready handshake.
- For every accepted command, raises a one-hot take_action or take_no_action pulse and a registered jdo word. Replaces the fixed 2-bit-IR, 38-bit, unbuffered decoder.

Parameters:
- IR_W, 2, virtual JTAG IR width; 2**IR_W command channels
- DR_W, 38, scan/data register width (width of sr, jdo, cmd_data)
- SYNC_STAGES, 2, synchroniser flops per strobe (minimum 2)
- ACTION_BIT, 35, bit of sr selecting action (1) or no-action (0)
- FIFO_DEPTH, 2, command queue entries, power of 2, ≥2
- TIMEOUT_CYCLES, 1024, stall limit (used only with the optional feature)

Ports:
- clk, in, 1, system clock
- reset, in, 1, synchronous active-high reset
- vs_uir, in, 1, update-IR level from TCK domain (asynchronous)
- vs_udr, in, 1, update-DR level from TCK domain (asynchronous)
- ir_in, in, IR_W, virtual JTAG IR; stable while vs_uir is high and until the next update
- sr, in, DR_W, TCK-domain shift register; stable from the vs_udr rise until the next capture
- cmd_valid, out, 1, FIFO head valid
- cmd_ready, in, 1, CPU debug logic accepts head
- cmd_ir, out, IR_W, head command channel
- cmd_data, out, DR_W, head data
- jdo, out, DR_W, registered data of last accepted command
- take_action, out, 2**IR_W, one-hot single-cycle action pulse
- take_no_action, out, 2**IR_W, one-hot single-cycle no-action pulse
- overrun, out, 1, sticky: a command was dropped on a full FIFO
- overrun_clr, in, 1, clears overrun
- timeout, out, 1, sticky stall flag (0 without the optional feature)

Behaviour:
- Clocking and reset: single clock clk. Reset is synchronous, active-high, on port reset.
- Reset values: synchroniser flops 0; edge-detect history 1; FIFO empty; cmd_valid 0; jdo 0; take_action/take_no_action 0; overrun 0; timeout 0; IR latch 0; timeout counter 0.
  - Because history resets to 1, a strobe already high at reset release is ignored. An edge is recognised only after the synchronised level has been seen low.
- Edge detect: rise = sync_out & ~hist. Latency from an input transition to the rise pulse is SYNC_STAGES+1 cycles.
- uir rise: IR latch <= ir_in.
- udr rise: push {IR latch, sr}.
  - If uir rise and udr rise occur in the same cycle, the push uses the new ir_in.
- Push on full:
  - Accepted only if a pop happens in the same cycle.
  - Otherwise the entry is dropped and overrun is set.
- overrun: set has priority over overrun_clr in the same cycle.
- FIFO: no bypass. A push at cycle N gives cmd_valid=1 at N+1.
  - cmd_ir and cmd_data show the head whenever cmd_valid=1; they are don't-care otherwise.
  - Pop occurs when cmd_valid & cmd_ready.
  - Pointers wrap modulo FIFO_DEPTH. An extra wrap bit distinguishes full from empty.
- Pop at cycle P, registered outputs valid at P+1 for exactly one cycle:
  - jdo <= head data; jdo holds between pops.
  - If head data[ACTION_BIT]=1: take_action[head ir]=1, otherwise take_no_action[head ir]=1.
  - All other bits of both vectors are 0. Back-to-back pops give consecutive pulses.
- Reset mid-operation: queued entries and in-flight pulses are discarded. No pulse is emitted in the cycle after reset.

Optional Feature:
- Macro: NIOS_DBG_CMD_TIMEOUT_EN.
- With the macro defined:
  - A counter increments each cycle cmd_valid & ~cmd_ready and clears on any pop.
  - On reaching TIMEOUT_CYCLES-1, the head is discarded on the next cycle: popped with no take_* pulse and jdo unchanged.
  - timeout is set, sticky, and cleared by overrun_clr.
- Without the macro: no counter; timeout is constant 0; the head waits indefinitely.

Decomposition:
- Package nios_dbg_pkg holds:
  - command channel enum (OCIMEM=0, TRACEMEM=1, BREAK=2, TRACECTRL=3 for IR_W=2)
  - FIFO entry struct {ir, data}
  - default width constants
- Sub-module nios_dbg_strobe_sync (SYNC_STAGES synchroniser + edge detect), instantiated for vs_uir and vs_udr.

Test Plan:
- Reset released with vs_udr=1 held → no push, cmd_valid stays 0. Then drop vs_udr, raise it again → one entry pushed.
- ir_in=2, uir pulse, then sr bit35=1, sr[31:0]=0xDEADBEEF, udr pulse, cmd_ready=1:
  - cmd_valid asserts SYNC_STAGES+2 cycles after the udr rise;
  - next cycle take_action=4'b0100 for one cycle and jdo[31:0]=0xDEADBEEF.
- cmd_ready=0, three udr pulses with FIFO_DEPTH=2 → two entries held and overrun=1. Then cmd_ready=1 → two pulses in consecutive cycles, data order preserved. overrun_clr → overrun=0.
- FIFO full, pop and push in the same cycle → push accepted, overrun stays 0, occupancy stays 2.
- With NIOS_DBG_CMD_TIMEOUT_EN, TIMEOUT_CYCLES=8, cmd_ready=0 → head dropped after 8 stalled cycles, no take_* pulse, timeout=1. Without the macro → cmd_valid stays 1 indefinitely and timeout=0.
- Reset asserted with 2 entries queued → next cycle cmd_valid=0, no pulses, jdo=0.
